// File: rtl/snitch_icache_pkg.sv
// rtl/snitch_icache_pkg.sv - shared instruction cache configuration
package snitch_icache_pkg;

  typedef struct packed {
    int unsigned FETCH_AW;
    int unsigned ID_WIDTH;
    int unsigned WAY_COUNT;
    int unsigned WAY_ALIGN;
    int unsigned LINE_WIDTH;
    int unsigned LINE_ALIGN;
    int unsigned COUNT_ALIGN;
    int unsigned TAG_WIDTH;
  } config_t;

  // Keeps vector widths legal when a field is left at its zero default.
  function automatic int unsigned at_least_one(int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/snitch_icache_victim_sel.sv
// rtl/snitch_icache_victim_sel.sv - round-robin victim way counter
module snitch_icache_victim_sel #(
  parameter int unsigned WAY_COUNT = 1,
  parameter int unsigned WAY_ALIGN = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 advance_i,
  output logic [WAY_ALIGN-1:0] way_o
);

  if (WAY_COUNT <= 1) begin : g_single_way
    logic unused;
    assign unused = ^{clk_i, rst_ni, advance_i};
    assign way_o  = '0;
  end else begin : g_round_robin
    logic [WAY_ALIGN-1:0] way_q;

    // Explicit wrap so non-power-of-two way counts never select a missing way.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        way_q <= '0;
      end else if (advance_i) begin
        way_q <= (way_q == WAY_ALIGN'(WAY_COUNT - 1)) ? '0 : way_q + 1'b1;
      end
    end

    assign way_o = way_q;
  end

endmodule

// File: rtl/snitch_icache_l1_refill.sv
// rtl/snitch_icache_l1_refill.sv - L1 hit pass-through and single-miss refill writer
module snitch_icache_l1_refill
  import snitch_icache_pkg::*;
#(
  parameter config_t CFG = '0
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [at_least_one(CFG.FETCH_AW)-1:0]     lookup_addr_i,
  input  logic [at_least_one(CFG.ID_WIDTH)-1:0]     lookup_id_i,
  input  logic                                      lookup_hit_i,
  input  logic [at_least_one(CFG.LINE_WIDTH)-1:0]   lookup_data_i,
  input  logic                                      lookup_error_i,
  input  logic                                      lookup_valid_i,
  output logic                                      lookup_ready_o,
  output logic [at_least_one(CFG.LINE_WIDTH)-1:0]   rsp_data_o,
  output logic                                      rsp_error_o,
  output logic [at_least_one(CFG.ID_WIDTH)-1:0]     rsp_id_o,
  output logic                                      rsp_valid_o,
  input  logic                                      rsp_ready_i,
  output logic [at_least_one(CFG.FETCH_AW)-1:0]     refill_addr_o,
  output logic [at_least_one(CFG.ID_WIDTH)-1:0]     refill_id_o,
  output logic                                      refill_valid_o,
  input  logic                                      refill_ready_i,
  input  logic [at_least_one(CFG.LINE_WIDTH)-1:0]   refill_data_i,
  input  logic                                      refill_error_i,
  input  logic                                      refill_rvalid_i,
  output logic                                      refill_rready_o,
  output logic [at_least_one(CFG.COUNT_ALIGN)-1:0]  write_addr_o,
  output logic [at_least_one(CFG.WAY_ALIGN)-1:0]    write_way_o,
  output logic [at_least_one(CFG.LINE_WIDTH)-1:0]   write_data_o,
  output logic [at_least_one(CFG.TAG_WIDTH)-1:0]    write_tag_o,
  output logic                                      write_error_o,
  output logic                                      write_valid_o,
  input  logic                                      write_ready_i,
  output logic                                      refill_event_o
);

  localparam int unsigned FAW = at_least_one(CFG.FETCH_AW);
  localparam int unsigned IDW = at_least_one(CFG.ID_WIDTH);
  localparam int unsigned LW  = at_least_one(CFG.LINE_WIDTH);
  localparam int unsigned CA  = at_least_one(CFG.COUNT_ALIGN);
  localparam int unsigned WA  = at_least_one(CFG.WAY_ALIGN);
  localparam int unsigned WC  = at_least_one(CFG.WAY_COUNT);
  localparam int unsigned TW  = at_least_one(CFG.TAG_WIDTH);
  localparam int unsigned LA  = CFG.LINE_ALIGN;

  if (CFG.FETCH_AW != 0 && TW != FAW - LA - CA) begin : g_tag_width_check
    $error("TAG_WIDTH must equal FETCH_AW - LINE_ALIGN - COUNT_ALIGN");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_WRITE,
    ST_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [FAW-1:0]  addr_q;
  logic [IDW-1:0]  id_q;
  logic [LW-1:0]   data_q;
  logic            error_q;
  logic            capture_lookup, capture_refill, advance;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      data_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture_lookup) begin
        addr_q <= lookup_addr_i;
        id_q   <= lookup_id_i;
      end
      if (capture_refill) begin
        data_q  <= refill_data_i;
        error_q <= refill_error_i;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    lookup_ready_o  = 1'b0;
    rsp_valid_o     = 1'b0;
    rsp_data_o      = data_q;
    rsp_error_o     = error_q;
    rsp_id_o        = id_q;
    refill_valid_o  = 1'b0;
    refill_rready_o = 1'b0;
    write_valid_o   = 1'b0;
    refill_event_o  = 1'b0;
    capture_lookup  = 1'b0;
    capture_refill  = 1'b0;
    advance         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        rsp_valid_o    = lookup_valid_i & lookup_hit_i;
        rsp_data_o     = lookup_data_i;
        rsp_error_o    = lookup_error_i;
        rsp_id_o       = lookup_id_i;
        lookup_ready_o = lookup_hit_i ? rsp_ready_i : 1'b1;
        if (lookup_valid_i && !lookup_hit_i) begin
          capture_lookup = 1'b1;
          state_d        = ST_REQ;
        end
      end
      ST_REQ: begin
        refill_valid_o = 1'b1;
        if (refill_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        refill_rready_o = 1'b1;
        if (refill_rvalid_i) begin
          capture_refill = 1'b1;
          state_d        = ST_WRITE;
        end
      end
      ST_WRITE: begin
        write_valid_o = 1'b1;
        if (write_ready_i) begin
          refill_event_o = 1'b1;
          advance        = 1'b1;
          state_d        = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Payloads are driven straight from the capture registers, so they stay stable while stalled.
  assign refill_addr_o = (addr_q >> LA) << LA;
  assign refill_id_o   = id_q;
  assign write_addr_o  = CA'(addr_q >> LA);
  assign write_tag_o   = TW'(addr_q >> (LA + CA));
  assign write_data_o  = data_q;
  assign write_error_o = error_q;

  snitch_icache_victim_sel #(
    .WAY_COUNT (WC),
    .WAY_ALIGN (WA)
  ) i_victim_sel (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .advance_i (advance),
    .way_o     (write_way_o)
  );

endmodule

// File: tb/tb_snitch_icache_l1_refill.sv
// tb/tb_snitch_icache_l1_refill.sv - scoreboard bench for the L1 refill stage
module tb_snitch_icache_l1_refill;
  import snitch_icache_pkg::*;

  localparam config_t CFG = '{FETCH_AW: 32, ID_WIDTH: 4, WAY_COUNT: 3, WAY_ALIGN: 2,
                              LINE_WIDTH: 128, LINE_ALIGN: 4, COUNT_ALIGN: 3, TAG_WIDTH: 25};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  lookup_addr_i = '0;
  logic [3:0]   lookup_id_i = '0;
  logic         lookup_hit_i = 1'b0;
  logic [127:0] lookup_data_i = '0;
  logic         lookup_error_i = 1'b0;
  logic         lookup_valid_i = 1'b0;
  logic         lookup_ready_o;
  logic [127:0] rsp_data_o;
  logic         rsp_error_o;
  logic [3:0]   rsp_id_o;
  logic         rsp_valid_o;
  logic         rsp_ready_i = 1'b0;
  logic [31:0]  refill_addr_o;
  logic [3:0]   refill_id_o;
  logic         refill_valid_o;
  logic         refill_ready_i = 1'b0;
  logic [127:0] refill_data_i = '0;
  logic         refill_error_i = 1'b0;
  logic         refill_rvalid_i = 1'b0;
  logic         refill_rready_o;
  logic [2:0]   write_addr_o;
  logic [1:0]   write_way_o;
  logic [127:0] write_data_o;
  logic [24:0]  write_tag_o;
  logic         write_error_o;
  logic         write_valid_o;
  logic         write_ready_i = 1'b0;
  logic         refill_event_o;

  snitch_icache_l1_refill #(.CFG(CFG)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lookup_addr_i(lookup_addr_i), .lookup_id_i(lookup_id_i), .lookup_hit_i(lookup_hit_i),
    .lookup_data_i(lookup_data_i), .lookup_error_i(lookup_error_i),
    .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
    .rsp_data_o(rsp_data_o), .rsp_error_o(rsp_error_o), .rsp_id_o(rsp_id_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .refill_addr_o(refill_addr_o), .refill_id_o(refill_id_o), .refill_valid_o(refill_valid_o),
    .refill_ready_i(refill_ready_i), .refill_data_i(refill_data_i),
    .refill_error_i(refill_error_i), .refill_rvalid_i(refill_rvalid_i),
    .refill_rready_o(refill_rready_o),
    .write_addr_o(write_addr_o), .write_way_o(write_way_o), .write_data_o(write_data_o),
    .write_tag_o(write_tag_o), .write_error_o(write_error_o), .write_valid_o(write_valid_o),
    .write_ready_i(write_ready_i), .refill_event_o(refill_event_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int events = 0;

  logic [35:0]  rq_q[$];
  logic [158:0] wq_q[$];
  logic [132:0] rsp_q[$];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic missing(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake seen with no expected entry", name);
  endtask

  // Monitor: every output handshake pops its scoreboard queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (refill_valid_o && refill_ready_i) begin
        if (rq_q.size() == 0) missing("refill_req");
        else chk("refill_req", 160'({refill_addr_o, refill_id_o}), 160'(rq_q.pop_front()));
      end
      if (write_valid_o && write_ready_i) begin
        if (wq_q.size() == 0) missing("write");
        else chk("write", 160'({write_addr_o, write_way_o, write_tag_o, write_error_o, write_data_o}),
                 160'(wq_q.pop_front()));
      end
      if (rsp_valid_o && rsp_ready_i) begin
        if (rsp_q.size() == 0) missing("rsp");
        else chk("rsp", 160'({rsp_data_o, rsp_error_o, rsp_id_o}), 160'(rsp_q.pop_front()));
      end
      if (refill_event_o) events++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_miss(input logic [31:0] a, input logic [3:0] id, input logic [127:0] d,
                         input logic e, input int stall, input logic [31:0] ra,
                         input logic [2:0] widx, input logic [24:0] tag, input logic [1:0] way,
                         input bit overlap);
    int ev0;
    ev0 = events;
    rq_q.push_back({ra, id});
    wq_q.push_back({widx, way, tag, e, d});
    rsp_q.push_back({d, e, id});
    rsp_ready_i = 1'b0;
    lookup_valid_i = 1'b1; lookup_hit_i = 1'b0; lookup_addr_i = a; lookup_id_i = id;
    @(negedge clk);
    chk("miss_accept", 160'(lookup_ready_o), 160'(1));
    step();
    lookup_valid_i = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("req_hold", 160'({refill_valid_o, refill_addr_o, refill_id_o}), 160'({1'b1, ra, id}));
      step();
    end
    refill_ready_i = 1'b1;
    step();
    refill_ready_i = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("wait_hold", 160'({refill_rready_o, write_valid_o}), 160'(2'b10));
      step();
    end
    refill_rvalid_i = 1'b1; refill_data_i = d; refill_error_i = e;
    step();
    refill_rvalid_i = 1'b0; refill_data_i = '0; refill_error_i = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("write_hold", 160'({write_valid_o, write_way_o, write_addr_o, write_tag_o, write_error_o, write_data_o}),
          160'({1'b1, way, widx, tag, e, d}));
      step();
    end
    write_ready_i = 1'b1;
    step();
    write_ready_i = 1'b0;
    if (overlap) begin
      lookup_valid_i = 1'b1; lookup_hit_i = 1'b0; lookup_addr_i = a ^ 32'h100;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("resp_hold", 160'({rsp_valid_o, rsp_error_o, rsp_id_o, rsp_data_o, lookup_ready_o}),
          160'({1'b1, e, id, d, 1'b0}));
      step();
    end
    rsp_ready_i = 1'b1;
    if (overlap) begin
      @(negedge clk);
      chk("overlap_blocked", 160'(lookup_ready_o), 160'(0));
    end
    step();
    rsp_ready_i = 1'b0;
    lookup_valid_i = 1'b0;
    chk("one_event", 160'(events - ev0), 160'(1));
  endtask

  initial begin
    #3;
    chk("reset_valids", 160'({refill_valid_o, refill_rready_o, write_valid_o, rsp_valid_o, refill_event_o}), 160'(0));
    chk("reset_payload", 160'({refill_addr_o, write_way_o, write_tag_o, write_data_o}), 160'(0));
    step();
    rst_n = 1'b1;

    // Hits pass through combinationally.
    rsp_q.push_back({{4{32'hA5A5_A5A5}}, 1'b0, 4'd3});
    lookup_valid_i = 1'b1; lookup_hit_i = 1'b1; lookup_id_i = 4'd3;
    lookup_data_i = {4{32'hA5A5_A5A5}}; lookup_error_i = 1'b0; rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("hit_ready", 160'(lookup_ready_o), 160'(1));
    step();
    rsp_ready_i = 1'b0; lookup_id_i = 4'd5;
    @(negedge clk);
    chk("hit_backpressure", 160'({lookup_ready_o, rsp_valid_o, rsp_id_o}), 160'({1'b0, 1'b1, 4'd5}));
    step();
    rsp_q.push_back({{4{32'h1111_2222}}, 1'b1, 4'd7});
    lookup_id_i = 4'd7; lookup_data_i = {4{32'h1111_2222}}; lookup_error_i = 1'b1; rsp_ready_i = 1'b1;
    step();
    lookup_valid_i = 1'b0; lookup_hit_i = 1'b0; lookup_error_i = 1'b0; rsp_ready_i = 1'b0;

    do_miss(32'h0000_1234, 4'd1, {4{32'hDEAD_BEEF}}, 1'b0, 0, 32'h0000_1230, 3'd3, 25'h24, 2'd0, 1'b0);
    do_miss(32'h0000_ABCD, 4'd2, {4{32'h0123_4567}}, 1'b0, 5, 32'h0000_ABC0, 3'd4, 25'h157, 2'd1, 1'b0);
    do_miss(32'hFFFF_FFFF, 4'd15, {4{32'hCAFE_F00D}}, 1'b1, 1, 32'hFFFF_FFF0, 3'd7, 25'h1FF_FFFF, 2'd2, 1'b0);
    do_miss(32'h8000_0010, 4'd4, {4{32'h5A5A_0F0F}}, 1'b0, 2, 32'h8000_0010, 3'd1, 25'h100_0000, 2'd0, 1'b1);

    // Asynchronous reset while waiting for the refill response.
    rq_q.push_back({32'h0000_5550, 4'd6});
    lookup_valid_i = 1'b1; lookup_hit_i = 1'b0; lookup_addr_i = 32'h0000_5555; lookup_id_i = 4'd6;
    step();
    lookup_valid_i = 1'b0; refill_ready_i = 1'b1;
    step();
    refill_ready_i = 1'b0;
    @(negedge clk);
    chk("wait_before_reset", 160'(refill_rready_o), 160'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_drops_valids", 160'({refill_rready_o, refill_valid_o, write_valid_o, rsp_valid_o}), 160'(0));
    step();
    rst_n = 1'b1;

    do_miss(32'h0000_0080, 4'd9, {4{32'h7777_8888}}, 1'b0, 0, 32'h0000_0080, 3'd0, 25'h1, 2'd0, 1'b0);

    repeat (2) step();
    chk("rq_drained", 160'(rq_q.size()), 160'(0));
    chk("wq_drained", 160'(wq_q.size()), 160'(0));
    chk("rsp_drained", 160'(rsp_q.size()), 160'(0));
    chk("event_total", 160'(events), 160'(5));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
